// File: rtl/gpu_mem_pkg.sv
// Shared memory-controller package.
// Holds the per-channel FSM state type and the owner-index width helper
// used by the data- and program-memory channel controllers.
package gpu_mem_pkg;

    // Per-channel controller states.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        READ_WAIT   = 3'd1,
        WRITE_WAIT  = 3'd2,
        READ_RELAY  = 3'd3,
        WRITE_RELAY = 3'd4
    } chan_state_t;

    // Width of an index into n consumers (at least one bit).
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated find-first: returns the first set bit of req at or after start,
// wrapping around at N.
// Ports: req   - request vector
//        start - search start index (must be < N)
//        found - some request bit was set
//        idx   - index of the selected request (0 when none)
module rr_pick
    import gpu_mem_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = idx_bits(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    localparam int unsigned W1 = W + 1;

    logic [W:0] pos;

    // Scan offsets high to low so the smallest offset from start wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = W1'(start) + W1'(i);
            if (pos >= W1'(N)) begin
                pos = pos - W1'(N);
            end
            if (req[pos[W-1:0]]) begin
                found = 1'b1;
                idx   = pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/lsu_channel_arbiter.sv
// Shares NUM_CHANNELS external data-memory channels among NUM_CONSUMERS LSUs.
// Each channel runs its own FSM; idle channels pick pending consumers
// round-robin from a shared pointer, lowest channel first, in one cycle.
// Ports: clk, reset (async, active low)
//        consumer_read_*  - per-LSU read request / completion
//        consumer_write_* - per-LSU write request / completion
//        mem_read_*       - per-channel memory read port
//        mem_write_*      - per-channel memory write port
module lsu_channel_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 8,
    parameter int unsigned NUM_CHANNELS  = 4
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int unsigned CW = idx_bits(NUM_CONSUMERS);

    chan_state_t              state [NUM_CHANNELS];
    logic [CW-1:0]            owner [NUM_CHANNELS];
    logic [CW-1:0]            rr_ptr;
    logic [NUM_CONSUMERS-1:0] owned;
    logic [NUM_CONSUMERS-1:0] pending;
    logic [NUM_CHANNELS-1:0]  pick_found;
    logic [CW-1:0]            pick_idx [NUM_CHANNELS];
    logic                     any_grant;
    logic [CW-1:0]            last_idx;
    logic [CW-1:0]            next_ptr;

    // A consumer stays owned from grant until its channel is back in IDLE.
    always_comb begin
        owned = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (state[ch] != IDLE) begin
                owned[owner[ch]] = 1'b1;
            end
        end
    end

    assign pending = (consumer_read_valid | consumer_write_valid) & ~owned;

    // Picker chain: each stage sees the requests left over by lower channels.
    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_pick
        logic [NUM_CONSUMERS-1:0] req_in;
        logic [NUM_CONSUMERS-1:0] req_out;
        logic                     found;
        logic                     grant;
        logic [CW-1:0]            idx;

        if (ch == 0) begin : g_first
            assign req_in = pending;
        end else begin : g_next
            assign req_in = g_pick[ch-1].req_out;
        end

        rr_pick #(
            .N (NUM_CONSUMERS),
            .W (CW)
        ) u_pick (
            .req   (req_in),
            .start (rr_ptr),
            .found (found),
            .idx   (idx)
        );

        assign grant          = found && (state[ch] == IDLE);
        assign req_out        = grant ? (req_in & ~(NUM_CONSUMERS'(1) << idx)) : req_in;
        assign pick_found[ch] = grant;
        assign pick_idx[ch]   = idx;
    end

    // The highest granting channel holds the last consumer taken this cycle.
    always_comb begin
        any_grant = 1'b0;
        last_idx  = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (pick_found[ch]) begin
                any_grant = 1'b1;
                last_idx  = pick_idx[ch];
            end
        end
        next_ptr = (last_idx == CW'(NUM_CONSUMERS - 1)) ? '0 : last_idx + 1'b1;
    end

    // Channel FSMs, pointer and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr               <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
            mem_read_valid       <= '0;
            mem_read_address     <= '0;
            mem_write_valid      <= '0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state[ch] <= IDLE;
                owner[ch] <= '0;
            end
        end else begin
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state[ch])
                    IDLE: begin
                        if (pick_found[ch]) begin
                            owner[ch] <= pick_idx[ch];
                            // Read wins when both are requested; the write stays pending.
                            if (consumer_read_valid[pick_idx[ch]]) begin
                                state[ch]            <= READ_WAIT;
                                mem_read_valid[ch]   <= 1'b1;
                                mem_read_address[ch] <= consumer_read_address[pick_idx[ch]];
                            end else begin
                                state[ch]             <= WRITE_WAIT;
                                mem_write_valid[ch]   <= 1'b1;
                                mem_write_address[ch] <= consumer_write_address[pick_idx[ch]];
                                mem_write_data[ch]    <= consumer_write_data[pick_idx[ch]];
                            end
                        end
                    end
                    READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            consumer_read_data[owner[ch]]  <= mem_read_data[ch];
                            consumer_read_ready[owner[ch]] <= 1'b1;
                            mem_read_valid[ch]             <= 1'b0;
                            state[ch]                      <= READ_RELAY;
                        end
                    end
                    WRITE_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            consumer_write_ready[owner[ch]] <= 1'b1;
                            mem_write_valid[ch]             <= 1'b0;
                            state[ch]                       <= WRITE_RELAY;
                        end
                    end
                    READ_RELAY: begin
                        if (!consumer_read_valid[owner[ch]]) begin
                            consumer_read_ready[owner[ch]] <= 1'b0;
                            state[ch]                      <= IDLE;
                        end
                    end
                    WRITE_RELAY: begin
                        if (!consumer_write_valid[owner[ch]]) begin
                            consumer_write_ready[owner[ch]] <= 1'b0;
                            state[ch]                       <= IDLE;
                        end
                    end
                    default: state[ch] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_channel_arbiter.sv
// Self-checking bench for lsu_channel_arbiter: a vector table of single
// transactions plus directed sequences for saturation, round-robin rotation,
// read+write on one consumer and reset in mid-transaction.
module tb_lsu_channel_arbiter;

    localparam int unsigned AB  = 8;
    localparam int unsigned DB  = 8;
    localparam int unsigned NC  = 8;
    localparam int unsigned NCH = 4;
    localparam int unsigned NV  = 6;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NC-1:0]          consumer_read_valid;
    logic [NC-1:0][AB-1:0]  consumer_read_address;
    logic [NC-1:0]          consumer_read_ready;
    logic [NC-1:0][DB-1:0]  consumer_read_data;
    logic [NC-1:0]          consumer_write_valid;
    logic [NC-1:0][AB-1:0]  consumer_write_address;
    logic [NC-1:0][DB-1:0]  consumer_write_data;
    logic [NC-1:0]          consumer_write_ready;
    logic [NCH-1:0]         mem_read_valid;
    logic [NCH-1:0][AB-1:0] mem_read_address;
    logic [NCH-1:0]         mem_read_ready;
    logic [NCH-1:0][DB-1:0] mem_read_data;
    logic [NCH-1:0]         mem_write_valid;
    logic [NCH-1:0][AB-1:0] mem_write_address;
    logic [NCH-1:0][DB-1:0] mem_write_data;
    logic [NCH-1:0]         mem_write_ready;

    lsu_channel_arbiter #(
        .ADDR_BITS     (AB),
        .DATA_BITS     (DB),
        .NUM_CONSUMERS (NC),
        .NUM_CHANNELS  (NCH)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Memory latency per channel, in cycles from valid rising to ready sampled.
    int unsigned lat [NCH];

    int          rd_done [NC];
    int          wr_done [NC];
    int          rd_cyc  [NC];
    int          wr_cyc  [NC];
    logic [7:0]  rd_data [NC];
    int          g_cnt   [NCH];
    logic [7:0]  g_last  [NCH];

    int unsigned rot_p  [3] = '{3, 6, 2};
    int unsigned rot_e0 [3] = '{5, 0, 5};
    int unsigned rot_e1 [3] = '{0, 5, 0};

    typedef struct packed {
        logic       wr;
        logic [2:0] cons;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [3:0] lat;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs handshakes until every consumer request has completed.
    task automatic serve_all(input int maxc);
        logic [NCH-1:0] prev;
        int n;
        prev = mem_read_valid;
        n = 0;
        while ((consumer_read_valid | consumer_write_valid |
                consumer_read_ready | consumer_write_ready) != '0 && n < maxc) begin
            step();
            n++;
            for (int ch = 0; ch < NCH; ch++) begin
                if (mem_read_valid[ch] && !prev[ch]) begin
                    g_cnt[ch]++;
                    g_last[ch] = mem_read_address[ch];
                end
            end
            prev = mem_read_valid;
            for (int c = 0; c < NC; c++) begin
                if (consumer_read_ready[c] && consumer_read_valid[c]) begin
                    rd_done[c]++;
                    rd_data[c] = consumer_read_data[c];
                    rd_cyc[c]  = n;
                    consumer_read_valid[c] = 1'b0;
                end
                if (consumer_write_ready[c] && consumer_write_valid[c]) begin
                    wr_done[c]++;
                    wr_cyc[c] = n;
                    consumer_write_valid[c] = 1'b0;
                end
            end
        end
        check("serve_drained", 64'({consumer_read_valid, consumer_write_valid,
                                    consumer_read_ready, consumer_write_ready}), 64'd0);
    endtask

    task automatic clear_log();
        for (int c = 0; c < NC; c++) begin
            rd_done[c] = 0; wr_done[c] = 0; rd_cyc[c] = 0; wr_cyc[c] = 0; rd_data[c] = '0;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            g_cnt[ch] = 0; g_last[ch] = '0;
        end
    endtask

    // Memory model: ready after lat negedges of valid, data = address ^ 0x4A.
    initial begin
        int unsigned rcnt [NCH];
        int unsigned wcnt [NCH];
        mem_read_ready  = '0;
        mem_read_data   = '0;
        mem_write_ready = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            rcnt[ch] = 0; wcnt[ch] = 0;
        end
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (!mem_read_valid[ch]) begin
                    rcnt[ch] = 0;
                    mem_read_ready[ch] = 1'b0;
                end else if (!mem_read_ready[ch]) begin
                    rcnt[ch]++;
                    if (rcnt[ch] >= lat[ch]) begin
                        mem_read_ready[ch] = 1'b1;
                        mem_read_data[ch]  = mem_read_address[ch] ^ 8'h4A;
                    end
                end
                if (!mem_write_valid[ch]) begin
                    wcnt[ch] = 0;
                    mem_write_ready[ch] = 1'b0;
                end else if (!mem_write_ready[ch]) begin
                    wcnt[ch]++;
                    if (wcnt[ch] >= lat[ch]) begin
                        mem_write_ready[ch] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t                  v;
        int                    k;
        bit                    stable;
        logic [NC-1:0][DB-1:0] rsnap;

        //            wr    cons  addr   wdata  lat   rdata
        vecs[0] = '{1'b0, 3'd2, 8'h10, 8'h00, 4'd2, 8'h5A};
        vecs[1] = '{1'b1, 3'd7, 8'hFF, 8'hC3, 4'd4, 8'h00};
        vecs[2] = '{1'b0, 3'd0, 8'h00, 8'h00, 4'd1, 8'h4A};
        vecs[3] = '{1'b0, 3'd7, 8'hFF, 8'h00, 4'd3, 8'hB5};
        vecs[4] = '{1'b1, 3'd3, 8'h80, 8'h7E, 4'd1, 8'h00};
        vecs[5] = '{1'b0, 3'd5, 8'h33, 8'h00, 4'd5, 8'h79};

        reset                  = 1'b0;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        for (int ch = 0; ch < NCH; ch++) lat[ch] = 1;
        clear_log();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_valids", 64'({mem_read_valid, mem_write_valid,
                                 consumer_read_ready, consumer_write_ready}), 64'd0);
        check("rst_rdata", 64'(consumer_read_data), 64'd0);
        check("rst_maddr", 64'(mem_read_address), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Saturation: all eight read at once, four channels.
        for (int ch = 0; ch < NCH; ch++) lat[ch] = 3;
        for (int c = 0; c < NC; c++) consumer_read_address[c] = 8'h20 + 8'(c);
        consumer_read_valid = '1;
        step();
        check("sat_grant_valid", 64'(mem_read_valid), 64'hF);
        for (int ch = 0; ch < NCH; ch++)
            check($sformatf("sat_first_ch%0d", ch), 64'(mem_read_address[ch]), 64'(8'h20 + 8'(ch)));
        serve_all(200);
        for (int ch = 0; ch < NCH; ch++) begin
            check($sformatf("sat_second_cnt_ch%0d", ch), 64'(g_cnt[ch]), 64'd1);
            check($sformatf("sat_second_ch%0d", ch), 64'(g_last[ch]), 64'(8'h24 + 8'(ch)));
        end
        for (int c = 0; c < NC; c++) begin
            check($sformatf("sat_done_c%0d", c), 64'(rd_done[c]), 64'd1);
            check($sformatf("sat_data_c%0d", c), 64'(rd_data[c]), 64'((8'h20 + 8'(c)) ^ 8'h4A));
        end

        // Single-transaction vector table; an idle arbiter always uses channel 0.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            for (int ch = 0; ch < NCH; ch++) lat[ch] = 32'(v.lat);
            rsnap = consumer_read_data;
            if (v.wr) begin
                consumer_write_address[v.cons] = v.addr;
                consumer_write_data[v.cons]    = v.wdata;
                consumer_write_valid[v.cons]   = 1'b1;
            end else begin
                consumer_read_address[v.cons] = v.addr;
                consumer_read_valid[v.cons]   = 1'b1;
            end
            step();
            if (v.wr) begin
                check($sformatf("v%0d_wgrant", i), 64'(mem_write_valid), 64'd1);
                check($sformatf("v%0d_waddr", i), 64'(mem_write_address[0]), 64'(v.addr));
                check($sformatf("v%0d_wdata", i), 64'(mem_write_data[0]), 64'(v.wdata));
            end else begin
                check($sformatf("v%0d_rgrant", i), 64'(mem_read_valid), 64'd1);
                check($sformatf("v%0d_raddr", i), 64'(mem_read_address[0]), 64'(v.addr));
            end
            k = 0;
            stable = 1'b1;
            while (!(v.wr ? consumer_write_ready[v.cons] : consumer_read_ready[v.cons]) && k < 40) begin
                step();
                k++;
                if (v.wr && (mem_write_address[0] !== v.addr || mem_write_data[0] !== v.wdata ||
                             consumer_read_ready !== '0 || mem_read_valid !== '0 ||
                             consumer_read_data !== rsnap))
                    stable = 1'b0;
            end
            check($sformatf("v%0d_latency", i), 64'(k), 64'(v.lat));
            if (v.wr) begin
                check($sformatf("v%0d_wvalid_drop", i), 64'(mem_write_valid), 64'd0);
                check($sformatf("v%0d_stable", i), 64'(stable), 64'd1);
                consumer_write_valid[v.cons] = 1'b0;
            end else begin
                check($sformatf("v%0d_rdata", i), 64'(consumer_read_data[v.cons]), 64'(v.rdata));
                check($sformatf("v%0d_rvalid_drop", i), 64'(mem_read_valid), 64'd0);
                consumer_read_valid[v.cons] = 1'b0;
            end
            step();
            check($sformatf("v%0d_ready_drop", i),
                  64'({consumer_read_ready, consumer_write_ready}), 64'd0);
        end

        // Rotation: a lone request moves the pointer, then 0 and 5 contend.
        for (int ch = 0; ch < NCH; ch++) lat[ch] = 1;
        for (int r = 0; r < 3; r++) begin
            consumer_read_address[rot_p[r]] = 8'h40 + 8'(rot_p[r]);
            consumer_read_valid[rot_p[r]]   = 1'b1;
            serve_all(40);
            consumer_read_address[0] = 8'h40;
            consumer_read_address[5] = 8'h45;
            consumer_read_valid[0]   = 1'b1;
            consumer_read_valid[5]   = 1'b1;
            step();
            check($sformatf("rot%0d_valid", r), 64'(mem_read_valid), 64'h3);
            check($sformatf("rot%0d_ch0", r), 64'(mem_read_address[0]), 64'(8'h40 + 8'(rot_e0[r])));
            check($sformatf("rot%0d_ch1", r), 64'(mem_read_address[1]), 64'(8'h40 + 8'(rot_e1[r])));
            serve_all(40);
        end

        // Read and write from the same consumer: read first, write after.
        for (int ch = 0; ch < NCH; ch++) lat[ch] = 2;
        clear_log();
        consumer_read_address[1]  = 8'h66;
        consumer_write_address[1] = 8'h99;
        consumer_write_data[1]    = 8'h3C;
        consumer_read_valid[1]    = 1'b1;
        consumer_write_valid[1]   = 1'b1;
        step();
        check("rw_first_read", 64'({mem_read_valid, mem_write_valid}), 64'h10);
        serve_all(60);
        check("rw_rd_done", 64'(rd_done[1]), 64'd1);
        check("rw_wr_done", 64'(wr_done[1]), 64'd1);
        check("rw_rdata", 64'(rd_data[1]), 64'h2C);
        check("rw_order", 64'(rd_cyc[1] < wr_cyc[1]), 64'd1);
        check("rw_waddr", 64'(mem_write_address[0]), 64'h99);
        check("rw_wdata", 64'(mem_write_data[0]), 64'h3C);

        // Reset in the middle of a read.
        for (int ch = 0; ch < NCH; ch++) lat[ch] = 10;
        consumer_read_address[6] = 8'h77;
        consumer_read_valid[6]   = 1'b1;
        step();
        check("mid_grant", 64'(mem_read_valid), 64'd1);
        step();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valids", 64'({mem_read_valid, mem_write_valid,
                                     consumer_read_ready, consumer_write_ready}), 64'd0);
        check("mid_rst_rdata", 64'(consumer_read_data), 64'd0);
        check("mid_rst_maddr", 64'({mem_read_address, mem_write_address}), 64'd0);
        check("mid_rst_wdata", 64'(mem_write_data), 64'd0);
        consumer_read_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        for (int ch = 0; ch < NCH; ch++) lat[ch] = 1;
        consumer_read_address[3] = 8'h43;
        consumer_read_address[7] = 8'h47;
        consumer_read_valid[3]   = 1'b1;
        consumer_read_valid[7]   = 1'b1;
        step();
        check("post_rst_valid", 64'(mem_read_valid), 64'h3);
        check("post_rst_ch0", 64'(mem_read_address[0]), 64'h43);
        check("post_rst_ch1", 64'(mem_read_address[1]), 64'h47);
        serve_all(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
